pipelined_rca: RTL

- Parametrised, pipelined ripple-carry adder: WIDTH-bit operands split into SEG-bit segments, one segment added per pipeline stage, carry registered between stages.
- Successor to the fixed 16-bit combinational ripple adder. Used where wide adds must close timing at datapath clock rate.
- Streams one operation per cycle through a valid/ready handshake, with full-pipeline stall on backpressure. Adds a signed-overflow flag.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/rca_segment.sv | 31 +++
 rtl/pipelined_rca.sv | 116 +++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared parameter derivation and legality check for the pipelined adder
package adder_pkg;

    function automatic int calc_nseg(input int width, input int seg);
        return (seg > 0) ? width / seg : 1;
    endfunction

    function automatic bit params_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// rtl/rca_segment.sv - combinational SEG-bit ripple adder built from full_adder cells
module rca_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[SEG];
    // carry into the top bit, needed for the signed-overflow flag
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - pipelined ripple-carry adder, one SEG-bit segment per stage, valid/ready stream
module pipelined_rca
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = calc_nseg(WIDTH, SEG);

    if (!params_ok(WIDTH, SEG)) begin : g_param_check
        $error("pipelined_rca: WIDTH must be a non-zero multiple of SEG");
    end

    logic                      adv;
    logic [NSEG-1:0]           vld;
    logic [NSEG-1:0]           c_r;
    logic [WIDTH-1:0]          sum_r [NSEG];
    logic [WIDTH-1:0]          a_sk  [NSEG];
    logic [WIDTH-1:0]          b_sk  [NSEG];
    logic                      ovf_r;

    logic [NSEG-1:0][SEG-1:0]  seg_a;
    logic [NSEG-1:0][SEG-1:0]  seg_b;
    logic [NSEG-1:0][SEG-1:0]  seg_s;
    logic [NSEG-1:0]           seg_ci;
    logic [NSEG-1:0]           seg_co;
    logic                      c_msb_last;

    // the whole pipe moves together; any stall at the output freezes every stage
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        seg_a     = '0;
        seg_b     = '0;
        seg_ci    = '0;
        seg_a[0]  = A[SEG-1:0];
        seg_b[0]  = B[SEG-1:0];
        seg_ci[0] = cin;
        for (int k = 1; k < NSEG; k++) begin
            seg_a[k]  = a_sk[k-1][k*SEG +: SEG];
            seg_b[k]  = b_sk[k-1][k*SEG +: SEG];
            seg_ci[k] = c_r[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == NSEG - 1) begin : g_last
            rca_segment #(.SEG(SEG)) u_seg (
                .a     (seg_a[k]),
                .b     (seg_b[k]),
                .ci    (seg_ci[k]),
                .s     (seg_s[k]),
                .co    (seg_co[k]),
                .c_msb (c_msb_last)
            );
        end else begin : g_mid
            logic c_msb_unused;
            rca_segment #(.SEG(SEG)) u_seg (
                .a     (seg_a[k]),
                .b     (seg_b[k]),
                .ci    (seg_ci[k]),
                .s     (seg_s[k]),
                .co    (seg_co[k]),
                .c_msb (c_msb_unused)
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            c_r   <= '0;
            ovf_r <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                sum_r[k] <= '0;
                a_sk[k]  <= '0;
                b_sk[k]  <= '0;
            end
        end else if (adv) begin
            vld[0]   <= in_valid;
            c_r      <= seg_co;
            sum_r[0] <= WIDTH'(seg_s[0]);
            a_sk[0]  <= A;
            b_sk[0]  <= B;
            for (int k = 1; k < NSEG; k++) begin
                vld[k]                   <= vld[k-1];
                sum_r[k]                 <= sum_r[k-1];
                sum_r[k][k*SEG +: SEG]   <= seg_s[k];
                a_sk[k]                  <= a_sk[k-1];
                b_sk[k]                  <= b_sk[k-1];
            end
            ovf_r <= seg_co[NSEG-1] ^ c_msb_last;
        end
    end

    assign out_valid = vld[NSEG-1];
    assign sum       = sum_r[NSEG-1];
    assign cout      = c_r[NSEG-1];
    assign ovf       = ovf_r;

endmodule
